// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg : shared types and constants for the 7-segment scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg : combinational nibble to active-low 7-segment pattern
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = ~HEX_SEG_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver : multiplexed 7-segment scanner with double-buffered load.
// Optional leading-zero blanking with SEG_SCAN_LZB_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int BCNT_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_INIT = (BLANK_TICKS > 0) ? BCNT_W'(BLANK_TICKS - 1) : '0;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic                    boundary_d, boundary_q;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic                    w_lz_blank;
  logic                    w_accept;

  assign w_accept = load_valid & ~pend_full_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      bcnt_q       <= '0;
      boundary_q   <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      boundary_q   <= boundary_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    boundary_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          idx_d      = '0;
          boundary_d = 1'b1;
        end
        ST_SHOW, ST_BLANK: begin
          if (state_q == ST_SHOW && BLANK_TICKS > 0) begin
            state_d = ST_BLANK;
            bcnt_d  = BCNT_INIT;
          end else if (state_q == ST_BLANK && bcnt_q != '0) begin
            bcnt_d = bcnt_q - 1'b1;
          end else begin
            state_d = ST_SHOW;
            if (idx_q == LAST_IDX) begin
              idx_d      = '0;
              boundary_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Commit only what was pending before this cycle; a same-cycle load waits a frame.
  always_comb begin
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (boundary_d && pend_full_q) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (w_accept) begin
      pend_dig_d  = load_digits;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end
  end

  assign w_nibble = act_dig_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble_i (w_nibble),
    .seg_o    (w_dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [IDX_W-1:0] w_msnz;
  always_comb begin
    w_msnz = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (act_dig_q[4*i +: 4] != 4'h0) w_msnz = IDX_W'(i);
    end
  end
  assign w_lz_blank = (idx_q > w_msnz);
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = boundary_q;
    if (state_q == ST_SHOW) begin
      an_d[idx_q] = 1'b0;
      seg_d       = w_lz_blank ? SEG_OFF : w_dec_seg;
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  assign load_ready = ~pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver : directed self-checking bench for seg_scan_driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        tick0 = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_digits = '0;
  logic [3:0]  load_dp = '0;
  logic        load_ready, dp, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        load_ready0, dp0, frame_done0;
  logic [3:0]  an0;
  logic [6:0]  seg0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .BLANK_TICKS(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .load_valid(load_valid),
    .load_ready(load_ready), .load_digits(load_digits), .load_dp(load_dp),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  seg_scan_driver #(.NUM_DIGITS(4), .BLANK_TICKS(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick0), .load_valid(load_valid),
    .load_ready(load_ready0), .load_digits(load_digits), .load_dp(load_dp),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(frame_done0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic run_to_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      do_tick();
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    load_digits = d;
    load_dp     = p;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_tests++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %h want f", an); end
    n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_tests++; if (dp !== 1'b1 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ctl got dp=%b fd=%b rdy=%b want 1 0 1", dp, frame_done, load_ready); end
    reset_n = 1'b1;
    repeat (4) step();
    n_tests++; if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got an=%h seg=%h fd=%b want f 7f 0", an, seg, frame_done); end
  endtask

  task automatic test_load_display();
    load(16'h12AF, 4'b0001);
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_fall got %b want 0", load_ready); end
    do_tick();
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL first_frame_done got %b want 1", frame_done); end
    n_tests++; if (an !== 4'b1110 || seg !== 7'h0E || dp !== 1'b0) begin
      n_fail++; $display("FAIL digit0 got an=%b seg=%h dp=%b want 1110 0e 0", an, seg, dp); end
    n_tests++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_rise got %b want 1", load_ready); end
    do_tick();
    n_tests++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL blank got an=%h seg=%h dp=%b fd=%b want f 7f 1 0", an, seg, dp, frame_done); end
    do_tick();
    n_tests++; if (an !== 4'b1101 || seg !== 7'h08 || dp !== 1'b1) begin
      n_fail++; $display("FAIL digit1 got an=%b seg=%h dp=%b want 1101 08 1", an, seg, dp); end
    do_tick(); do_tick();
    n_tests++; if (an !== 4'b1011 || seg !== 7'h24) begin
      n_fail++; $display("FAIL digit2 got an=%b seg=%h want 1011 24", an, seg); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load(16'h3456, 4'b0000);
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL bp_first_ready got %b want 0", load_ready); end
    load_digits = 16'h789B;
    load_valid  = 1'b1;
    repeat (2) step();
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held_ready got %b want 0", load_ready); end
    run_to_frame(ok);
    load_valid = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_frame1 timeout got none want frame_done"); end
    n_tests++; if (an !== 4'b1110 || seg !== 7'h02) begin
      n_fail++; $display("FAIL bp_frame1_digit0 got an=%b seg=%h want 1110 02", an, seg); end
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_pending got %b want 0", load_ready); end
    run_to_frame(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_frame2 timeout got none want frame_done"); end
    n_tests++; if (seg !== 7'h03 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_frame2_digit0 got seg=%h rdy=%b want 03 1", seg, load_ready); end
  endtask

  task automatic test_no_blank();
    int offs = 0;
    int fds  = 0;
    logic [3:0] exp_an;
    for (int k = 1; k <= 8; k++) begin
      tick0 = 1'b1;
      step();
      if (k > 1 && an0 === 4'hF) offs++;
      tick0 = 1'b0;
      step();
      if (an0 === 4'hF) offs++;
      if (frame_done0 === 1'b1) fds++;
      exp_an = ~(4'b0001 << ((k - 1) % 4));
      n_tests++; if (an0 !== exp_an) begin
        n_fail++; $display("FAIL noblank_an tick %0d got %b want %b", k, an0, exp_an); end
    end
    n_tests++; if (offs != 0) begin n_fail++; $display("FAIL noblank_off_cycles got %0d want 0", offs); end
    n_tests++; if (fds != 2) begin n_fail++; $display("FAIL noblank_frames got %0d want 2", fds); end
  endtask

  task automatic test_lzb();
    bit ok;
    logic [6:0] exp_hi;
`ifdef SEG_SCAN_LZB_EN
    exp_hi = 7'h7F;
`else
    exp_hi = 7'h40;
`endif
    load(16'h0005, 4'b0000);
    run_to_frame(ok);
    n_tests++; if (!ok || an !== 4'b1110 || seg !== 7'h12) begin
      n_fail++; $display("FAIL lz_digit0 got ok=%b an=%b seg=%h want 1 1110 12", ok, an, seg); end
    do_tick(); do_tick();
    n_tests++; if (an !== 4'b1101 || seg !== exp_hi) begin
      n_fail++; $display("FAIL lz_digit1 got an=%b seg=%h want 1101 %h", an, seg, exp_hi); end
    load(16'h0000, 4'b0000);
    run_to_frame(ok);
    n_tests++; if (!ok || seg !== 7'h40) begin
      n_fail++; $display("FAIL lz_zero_digit0 got ok=%b seg=%h want 1 40", ok, seg); end
  endtask

  task automatic test_reset_in_blank();
    bit ok;
    do_tick();
    load(16'hEEEE, 4'hF);
    n_tests++; if (an !== 4'hF || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL rb_pre got an=%h rdy=%b want f 0", an, load_ready); end
    reset_n = 1'b0;
    step();
    n_tests++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL rb_reset got an=%h seg=%h dp=%b rdy=%b fd=%b want f 7f 1 1 0",
                         an, seg, dp, load_ready, frame_done); end
    reset_n = 1'b1;
    step();
    run_to_frame(ok);
    n_tests++; if (!ok || an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
      n_fail++; $display("FAIL rb_discarded got ok=%b an=%b seg=%h dp=%b want 1 1110 40 1", ok, an, seg, dp); end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_back_to_back();
    test_no_blank();
    test_lzb();
    test_reset_in_blank();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
